// File: rtl/rng_pkg.sv
// Shared types and the circular round-robin pick used by the RNG share arbiter.
package rng_pkg;

  localparam int unsigned RNG_WIDTH = 52;
  localparam int unsigned MAX_REQ   = 8;

  typedef logic [RNG_WIDTH-1:0] rng_word_t;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } arb_state_t;

  // One-hot of the first set req bit at or above ptr, searched circularly over n bits.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [2:0]         ptr,
                                                 input int unsigned        n);
    logic [MAX_REQ-1:0] pick;
    logic               found;
    logic [2:0]         idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = 3'((32'(ptr) + i) % n);
      if (i < n && !found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rng_share_arbiter_if.sv
// Generator, requester and debug signals of the RNG share arbiter.
interface rng_share_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = rng_pkg::RNG_WIDTH,
  parameter int unsigned OVR_W = 16
);
  import rng_pkg::*;

  logic [WIDTH-1:0] rnd_in;
  logic             rnd_valid;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [WIDTH-1:0] rnd_out;
  logic             ready;
  logic             word_avail;
  logic [OVR_W-1:0] overrun_cnt;

  modport master (
    input  rnd_in, rnd_valid, req,
    output gnt, rnd_out, ready, word_avail, overrun_cnt
  );

  modport slave (
    output rnd_in, rnd_valid, req,
    input  gnt, rnd_out, ready, word_avail, overrun_cnt
  );
endinterface

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin pick with a registered pointer that advances past each winner.
module rr_arbiter_core
  import rng_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] pick_c
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win_c;

  assign pick_c = N_REQ'(rr_pick(MAX_REQ'(req), 3'(ptr), N_REQ));

  always_comb begin
    win_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_c[i]) win_c = PTR_W'(i);
    end
  end

  // An empty request vector leaves the pointer where it is.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if (en && (|req)) begin
      ptr <= (win_c == PTR_W'(N_REQ - 1)) ? '0 : win_c + PTR_W'(1);
    end
  end

endmodule

// File: rtl/rng_share_arbiter.sv
// Hands each post-warm-up random word to exactly one requester, round-robin, counting lost words.
module rng_share_arbiter
  import rng_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = RNG_WIDTH,
  parameter int unsigned DISCARD = 2,
  parameter int unsigned OVR_W   = 16
) (
  input  logic           clk,
  input  logic           reset,
  rng_share_arbiter_if.master bus
);

  localparam int unsigned CNT_W = 4;

  arb_state_t       state;
  logic [CNT_W-1:0] disc_cnt;
  logic [WIDTH-1:0] hold;
  logic             avail;
  logic [N_REQ-1:0] gnt;
  logic [WIDTH-1:0] rnd_out;
  logic             ready;
  logic [OVR_W-1:0] ovr_cnt;
  logic             grant_c;
  logic [N_REQ-1:0] pick_c;

  assign grant_c = (state == RUN) && avail && (|bus.req);

  rr_arbiter_core #(.N_REQ(N_REQ)) u_core (
    .clk    (clk),
    .reset  (reset),
    .req    (bus.req),
    .en     (grant_c),
    .pick_c (pick_c)
  );

  // The strobe that completes warm-up is consumed by the counter, never stored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= WARMUP;
      disc_cnt <= '0;
      hold     <= '0;
      avail    <= 1'b0;
      gnt      <= '0;
      rnd_out  <= '0;
      ready    <= 1'b0;
      ovr_cnt  <= '0;
    end else begin
      gnt <= grant_c ? pick_c : '0;
      if (grant_c) rnd_out <= hold;
      case (state)
        WARMUP: begin
          if (DISCARD == 0) begin
            state <= RUN;
            ready <= 1'b1;
          end else if (bus.rnd_valid) begin
            disc_cnt <= disc_cnt + CNT_W'(1);
            if (disc_cnt == CNT_W'(DISCARD - 1)) begin
              state <= RUN;
              ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.rnd_valid) begin
            hold  <= bus.rnd_in;
            avail <= 1'b1;
            if (avail && !grant_c && (ovr_cnt != '1)) ovr_cnt <= ovr_cnt + OVR_W'(1);
          end else if (grant_c) begin
            avail <= 1'b0;
          end
        end
        default: state <= WARMUP;
      endcase
    end
  end

  assign bus.gnt         = gnt;
  assign bus.rnd_out     = rnd_out;
  assign bus.ready       = ready;
  assign bus.word_avail  = avail;
  assign bus.overrun_cnt = ovr_cnt;

endmodule

// File: tb/tb_rng_share_arbiter.sv
// Scoreboard bench for rng_share_arbiter: directed scenarios plus randomized traffic vs a queue model.
module tb_rng_share_arbiter;

  localparam int unsigned N       = 4;
  localparam int unsigned W       = 52;
  localparam int unsigned DISCARD = 2;
  localparam int unsigned OVR_W   = 16;

  typedef struct {
    logic [N-1:0] g;
    logic [W-1:0] w;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  rng_share_arbiter_if #(.N_REQ(N), .WIDTH(W), .OVR_W(OVR_W)) bus ();

  rng_share_arbiter #(.N_REQ(N), .WIDTH(W), .DISCARD(DISCARD), .OVR_W(OVR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t         exp_q[$];
  logic [W-1:0] m_held[$];
  int           m_disc;
  bit           m_run;
  int           m_ptr;
  int           m_ovr;
  int           m_idx;
  bit           m_granted;
  logic [N-1:0] req_pend;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word is a queue entry; it is handed out whole or replaced.
  always @(posedge clk) begin
    if (!reset) begin
      m_disc = 0;
      m_run  = 1'b0;
      m_ptr  = 0;
      m_ovr  = 0;
      m_held.delete();
      exp_q.delete();
    end else begin
      m_granted = 1'b0;
      if (m_run && m_held.size() > 0 && bus.req != 0) begin
        for (int k = 0; k < N; k++) begin
          m_idx = (m_ptr + k) % N;
          if (!m_granted && bus.req[m_idx]) begin
            m_granted = 1'b1;
            exp_q.push_back('{g: N'(1 << m_idx), w: m_held[0]});
            m_held.delete();
            m_ptr = (m_idx + 1) % N;
          end
        end
      end
      if (!m_run) begin
        if (DISCARD == 0) m_run = 1'b1;
        else if (bus.rnd_valid) begin
          m_disc++;
          if (m_disc == DISCARD) m_run = 1'b1;
        end
      end else if (bus.rnd_valid) begin
        if (m_held.size() > 0) begin
          if (m_ovr < (1 << OVR_W) - 1) m_ovr++;
          m_held.delete();
        end
        m_held.push_back(bus.rnd_in);
      end
    end
  end

  // Monitor: every DUT grant must match the head of the expected queue.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.gnt != '0) begin
      if (exp_q.size() == 0) begin
        chk("gnt_unexpected", 64'(bus.gnt), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("gnt", 64'(bus.gnt), 64'(e.g));
        chk("rnd_out", 64'(bus.rnd_out), 64'(e.w));
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("gnt_missing", 64'(bus.gnt), 64'(e.g));
    end
    chk("ready", 64'(bus.ready), 64'(m_run));
    chk("word_avail", 64'(bus.word_avail), 64'(m_held.size() > 0));
    chk("overrun_cnt", 64'(bus.overrun_cnt), 64'(m_ovr));
  end

  // Requesters drop a bit in the cycle its grant is visible; add_req raises new requests.
  task automatic step(input logic v, input logic [W-1:0] w, input logic [N-1:0] add_req);
    @(negedge clk);
    req_pend      = (req_pend & ~bus.gnt) | add_req;
    bus.req       = req_pend;
    bus.rnd_valid = v;
    bus.rnd_in    = w;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0);
  endtask

  task automatic reset_and_warm();
    reset    = 1'b0;
    req_pend = '0;
    idle(2);
    reset = 1'b1;
    for (int i = 0; i < int'(DISCARD); i++) begin
      step(1'b1, W'({$urandom, $urandom}), '0);
      idle(2);
    end
  endtask

  initial begin
    reset         = 1'b0;
    req_pend      = '0;
    bus.req       = '0;
    bus.rnd_valid = 1'b0;
    bus.rnd_in    = '0;
    idle(3);
    chk("rst_gnt", 64'(bus.gnt), 64'(0));
    chk("rst_rnd_out", 64'(bus.rnd_out), 64'(0));
    chk("rst_ready", 64'(bus.ready), 64'(0));
    reset = 1'b1;

    // Warm-up: 0x1, 0x2 discarded, 0x3 goes to requester 0.
    step(1'b0, '0, 4'b0001);
    step(1'b1, W'(1), '0);
    idle(3);
    step(1'b1, W'(2), '0);
    idle(3);
    chk("warm_ready", 64'(bus.ready), 64'(1));
    step(1'b1, W'(3), '0);
    idle(5);

    // Round-robin with all requesters waiting.
    reset_and_warm();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, W'(32'hA + i), 4'b1111);
      idle(9);
    end

    // Overrun: three unclaimed words, then one request.
    reset_and_warm();
    step(1'b1, W'(32'h11), '0);
    idle(2);
    step(1'b1, W'(32'h22), '0);
    idle(2);
    step(1'b1, W'(32'h33), '0);
    idle(2);
    chk("ovr_two", 64'(bus.overrun_cnt), 64'(2));
    step(1'b0, '0, 4'b0100);
    idle(3);
    chk("ovr_drained", 64'(bus.word_avail), 64'(0));

    // Grant and new strobe in the same cycle.
    reset_and_warm();
    step(1'b1, W'(5), '0);
    idle(2);
    step(1'b1, W'(6), 4'b0010);
    idle(3);
    chk("simul_ovr", 64'(bus.overrun_cnt), 64'(0));
    step(1'b0, '0, 4'b0010);
    idle(3);

    // One word, two requesters: one grant only.
    reset_and_warm();
    step(1'b0, '0, 4'b0011);
    step(1'b1, W'(7), '0);
    idle(50);

    // Reset in the cycle a grant is being decided.
    reset_and_warm();
    step(1'b1, W'(9), '0);
    idle(2);
    step(1'b0, '0, 4'b0001);
    reset = 1'b0;
    step(1'b0, '0, '0);
    chk("midrst_gnt", 64'(bus.gnt), 64'(0));
    chk("midrst_rnd_out", 64'(bus.rnd_out), 64'(0));
    chk("midrst_avail", 64'(bus.word_avail), 64'(0));
    reset    = 1'b1;
    req_pend = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, W'(32'h40 + i), '0);
      idle(3);
    end

    // Randomized traffic.
    reset_and_warm();
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 3) == 0), W'({$urandom, $urandom}),
           ($urandom_range(0, 5) == 0) ? N'($urandom) : '0);
    end
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rng_share_arbiter.md
Name: rng_share_arbiter

Overview:
- Shares one 52-bit pseudo-random word source among N_REQ consumers, e.g. the separation-matrix weight-init and orthogonalisation units.
- Each generated word is delivered to exactly one consumer, so no two weight vectors are seeded identically.
- The first DISCARD words after reset are dropped because they are low-entropy while the LFSR leaves its 0xF seed.
- Round-robin grants; overrun words are counted for debug.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 52, random word width
- DISCARD, 2, words discarded after reset before serving (0..15)
- OVR_W, 16, width of saturating overrun counter

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- rnd_in  in  WIDTH  word from the random generator
- rnd_valid  in  1  single-cycle strobe: rnd_in holds a new word this cycle
- req  in  N_REQ  per-requester request level; held until granted
- gnt  out  N_REQ  one-hot grant, high for exactly one cycle
- rnd_out  out  WIDTH  word for the granted requester; valid while gnt != 0
- ready  out  1  warm-up complete, arbiter serving
- word_avail  out  1  holding register contains an unconsumed word
- overrun_cnt  out  OVR_W  count of words lost unconsumed (saturating)

Behaviour:
- All state changes occur on the rising edge of clk. Reset is sampled only at a clock edge while reset==0.
- Reset values:
  - gnt = 0, rnd_out = 0, ready = 0, word_avail = 0, overrun_cnt = 0
  - RR pointer = 0, discard counter = 0, FSM = WARMUP
  - Holding register = 0
- Reset asserted mid-operation aborts everything. A grant pending in the following cycle is not issued, and warm-up restarts.
- FSM WARMUP:
  - Each rnd_valid increments the discard counter. The word is not stored. req is ignored.
  - When the counter reaches DISCARD, go to RUN on that edge; ready = 1 from the next cycle.
  - If DISCARD = 0, reset exits directly to RUN on the first post-reset edge.
- FSM RUN:
  - Holding register plus fresh flag (word_avail).
  - The rnd_valid that completes warm-up is discarded. The first served word is the next strobe.
- Grant rule: if word_avail==1 and req!=0 in cycle t:
  - Winner = first set req bit at or above the RR pointer, searched circularly.
  - In cycle t+1: gnt = one-hot(winner), rnd_out = held word.
  - The pointer becomes (winner+1) mod N_REQ.
  - word_avail clears in t+1 unless a new word is loaded (see below).
- gnt is a registered pulse. In cycles without a grant, gnt = 0; rnd_out holds its last value.
- Requesters drop req in the cycle gnt is seen. req still high in the gnt cycle counts as a new request, served only when another word is available. No double use of a word is possible.
- rnd_valid in cycle t:
  - Grant issued from t: the old word goes to rnd_out, the new word loads, word_avail stays 1.
  - No grant and word_avail==1: the word is replaced, overrun_cnt += 1 (saturates at 2^OVR_W-1), word_avail stays 1.
  - word_avail==0: the word loads, word_avail = 1.
- Latency: a word strobed at t is grantable at t+1 (word_avail high). The earliest gnt is at t+2 with a requester already waiting.
- Maximum throughput is one grant per rnd_valid. Requesters starve only if the generator stops.
- req bits for indices ≥ N_REQ do not exist; there are no X-propagation shortcuts. An all-zero req leaves the pointer unchanged.

Decomposition:
- Package rng_pkg:
  - rng_word_t (logic [51:0])
  - state enum arb_state_t {WARMUP, RUN}
  - localparam RNG_WIDTH = 52
  - function rr_pick(req, ptr) returning a one-hot vector
- One natural sub-module: rr_arbiter_core (combinational round-robin pick plus registered pointer), parameterised by N_REQ.
- The top handles the FSM, holding register, counters and output registers.

Test Plan:
- Warm-up: DISCARD=2, reset low 3 cycles, rnd_valid pulses with 0x1, 0x2, 0x3, req=4'b0001 throughout.
  - ready rises after the 2nd strobe.
  - First gnt = 0001 with rnd_out=0x3, 2 cycles after the 3rd strobe.
- Round-robin: req=4'b1111 held, words 0xA, 0xB, 0xC, 0xD, 0xE strobed every 10 cycles.
  - gnt sequence is 0001, 0010, 0100, 1000, 0001.
  - rnd_out is 0xA..0xE respectively.
- Overrun: req=0, three strobes 0x11, 0x22, 0x33, then req=4'b0100.
  - overrun_cnt=2.
  - gnt=0100 with rnd_out=0x33.
  - word_avail=0 afterwards.
- Simultaneous events: word 0x5 held, req=4'b0010, rnd_valid with 0x6 in the same cycle.
  - Next cycle: gnt=0010, rnd_out=0x5, word_avail=1, overrun_cnt unchanged.
  - Then req=4'b0010 again: gnt=0010 with rnd_out=0x6.
- No reuse: req=4'b0011 held, a single word 0x7.
  - Exactly one gnt pulse (0001).
  - No further gnt for 50 cycles without a strobe.
- Mid-operation reset: assert reset in the cycle a grant is being decided.
  - gnt stays 0; all outputs return to reset values.
  - Warm-up repeats: 2 discarded words before the next grant.
